// File: rtl/hls_stream_width_fifo.sv
// Stream buffer and width downsizer: wide words enter a DEPTH-entry FIFO and
// leave as RATIO narrow lanes, with synchronous flush and occupancy reporting.
module hls_stream_width_fifo #(
    parameter int IN0_DATA_WIDTH  = 32,
    parameter int OUT0_DATA_WIDTH = 8,
    parameter int DEPTH           = 4,
    parameter int LSB_FIRST       = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN0_DATA_WIDTH-1:0]    din_rsc_dat,
    input  logic                         din_rsc_vld,
    output logic                         din_rsc_rdy,
    output logic [OUT0_DATA_WIDTH-1:0]   dout_rsc_dat,
    output logic                         dout_rsc_vld,
    input  logic                         dout_rsc_rdy,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level
);
    localparam int RATIO = IN0_DATA_WIDTH / OUT0_DATA_WIDTH;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int FW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    typedef enum logic {EMPTY, SHIFT} state_t;

    state_t                    state, state_next;
    logic [IN0_DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic [FW-1:0]             fill_q, fill_next;
    logic [IN0_DATA_WIDTH-1:0] word_q;
    logic [CW-1:0]             lane_cnt, lane_next, lane_sel;
    logic                      rdy_q, push, pop, out_hs, fifo_empty;

    assign fifo_empty = (fill_q == '0);
    assign out_hs     = (state == SHIFT) && dout_rsc_rdy;
    assign push       = din_rsc_vld && rdy_q && !flush;

    // Serialiser: reload straight from the FIFO on the last lane so word
    // boundaries carry no bubble; flush overrides everything.
    always_comb begin
        state_next = state;
        lane_next  = lane_cnt;
        pop        = 1'b0;
        case (state)
            EMPTY: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    lane_next  = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (out_hs) begin
                    if (lane_cnt != LAST_LANE) begin
                        lane_next = lane_cnt + 1'b1;
                    end else if (!fifo_empty) begin
                        pop       = 1'b1;
                        lane_next = '0;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
        endcase
        if (flush) begin
            state_next = EMPTY;
            lane_next  = '0;
            pop        = 1'b0;
        end
    end

    always_comb begin
        fill_next = fill_q;
        case ({push, pop})
            2'b10:   fill_next = fill_q + FW'(1);
            2'b01:   fill_next = fill_q - FW'(1);
            default: fill_next = fill_q;
        endcase
        if (flush) begin
            fill_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            lane_cnt <= '0;
            word_q   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state    <= state_next;
            lane_cnt <= lane_next;
            fill_q   <= fill_next;
            rdy_q    <= !flush && (fill_next < FW'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    word_q <= mem[rd_ptr];
                end
            end
        end
    end

    // Storage needs no reset; the pointers and fill count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din_rsc_dat;
        end
    end

    assign lane_sel     = (LSB_FIRST != 0) ? lane_cnt : (LAST_LANE - lane_cnt);
    assign dout_rsc_dat = word_q[lane_sel*OUT0_DATA_WIDTH +: OUT0_DATA_WIDTH];
    assign dout_rsc_vld = (state == SHIFT);
    assign din_rsc_rdy  = rdy_q;
    assign fill_level   = fill_q;

endmodule

// File: tb/tb_hls_stream_width_fifo.sv
// Directed bench: default, MSB-first and RATIO=1 instances checked against
// hand-computed lane sequences.
module tb_hls_stream_width_fifo;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic [31:0] din = '0;
    logic        din_vld = 1'b0, dout_rdy = 1'b0;
    logic        din_rdy, dout_vld, m_din_rdy, m_dout_vld;
    logic [7:0]  dout_dat, m_dout_dat;
    logic [2:0]  fill, m_fill, r1_fill;
    logic [31:0] r1_din = '0;
    logic        r1_vld = 1'b0, r1_dout_rdy = 1'b0;
    logic        r1_din_rdy, r1_dout_vld;
    logic [31:0] r1_dout_dat;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] lsb_seq;
        logic [31:0] msb_seq;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] bp_words [6];
    logic [31:0] sw [8];
    logic [31:0] fw [3];

    always #5 clk = ~clk;

    hls_stream_width_fifo dut (
        .clk(clk), .rst(rst), .din_rsc_dat(din), .din_rsc_vld(din_vld),
        .din_rsc_rdy(din_rdy), .dout_rsc_dat(dout_dat), .dout_rsc_vld(dout_vld),
        .dout_rsc_rdy(dout_rdy), .flush(flush), .fill_level(fill)
    );

    hls_stream_width_fifo #(.LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst(rst), .din_rsc_dat(din), .din_rsc_vld(din_vld),
        .din_rsc_rdy(m_din_rdy), .dout_rsc_dat(m_dout_dat), .dout_rsc_vld(m_dout_vld),
        .dout_rsc_rdy(dout_rdy), .flush(flush), .fill_level(m_fill)
    );

    hls_stream_width_fifo #(.OUT0_DATA_WIDTH(32)) dut_r1 (
        .clk(clk), .rst(rst), .din_rsc_dat(r1_din), .din_rsc_vld(r1_vld),
        .din_rsc_rdy(r1_din_rdy), .dout_rsc_dat(r1_dout_dat), .dout_rsc_vld(r1_dout_vld),
        .dout_rsc_rdy(r1_dout_rdy), .flush(flush), .fill_level(r1_fill)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; din_vld = 1'b0; r1_vld = 1'b0; flush = 1'b0;
        dout_rdy = 1'b0; r1_dout_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One word in an idle block: first lane two edges after the handshake.
    task automatic apply_stimulus(input vec_t v);
        din = v.word; din_vld = 1'b1; dout_rdy = 1'b1;
        check_output("vec_rdy", 32'(din_rdy), 32'd1);
        tick();
        din_vld = 1'b0;
        check_output("vec_latency", 32'(dout_vld), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_output("vec_vld", 32'(dout_vld), 32'd1);
            check_output("vec_lsb_lane", 32'(dout_dat), 32'(v.lsb_seq[8*i +: 8]));
            check_output("vec_msb_lane", 32'(m_dout_dat), 32'(v.msb_seq[8*i +: 8]));
            tick();
        end
        check_output("vec_idle", 32'(dout_vld), 32'd0);
    endtask

    task automatic feed(input logic ratio1);
        int   k = 0;
        logic hs;
        for (int c = 0; c < 100 && k < 8; c++) begin
            if (ratio1) begin
                r1_din = sw[k]; r1_vld = 1'b1; hs = r1_din_rdy;
            end else begin
                din = sw[k]; din_vld = 1'b1; hs = din_rdy;
            end
            tick();
            if (hs) k++;
        end
        din_vld = 1'b0;
        r1_vld = 1'b0;
        check_output("feed_done", 32'(k), 32'd8);
    endtask

    task automatic watch_lanes();
        int t = 0;
        while (!dout_vld && t < 10) begin
            tick();
            t++;
        end
        for (int j = 0; j < 32; j++) begin
            check_output("b2b_vld", 32'(dout_vld), 32'd1);
            check_output("b2b_dat", 32'(dout_dat), 32'(sw[j/4][8*(j%4) +: 8]));
            tick();
        end
    endtask

    task automatic watch_words();
        int t = 0;
        while (!r1_dout_vld && t < 10) begin
            tick();
            t++;
        end
        for (int j = 0; j < 8; j++) begin
            check_output("r1_vld", 32'(r1_dout_vld), 32'd1);
            check_output("r1_dat", r1_dout_dat, sw[j]);
            tick();
        end
    endtask

    initial begin
        int   acc;
        logic hs;
        vecs[0] = '{32'hDDCCBBAA, 32'hDDCCBBAA, 32'hAABBCCDD};
        vecs[1] = '{32'h11223344, 32'h11223344, 32'h44332211};
        vecs[2] = '{32'h00FF00FF, 32'h00FF00FF, 32'hFF00FF00};
        vecs[3] = '{32'h80000001, 32'h80000001, 32'h01000080};
        for (int k = 0; k < 6; k++) bp_words[k] = 32'h03020100 + 32'h10101010 * k;
        for (int k = 0; k < 8; k++) sw[k] = 32'h0B0A0908 + 32'h20202020 * k;
        fw[0] = 32'hA3A2A1A0; fw[1] = 32'hB3B2B1B0; fw[2] = 32'hC3C2C1C0;

        // Reset and release
        tick();
        check_output("rst_rdy", 32'(din_rdy), 32'd0);
        check_output("rst_vld", 32'(dout_vld), 32'd0);
        check_output("rst_fill", 32'(fill), 32'd0);
        check_output("rst_dat", 32'(dout_dat), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        check_output("rel_rdy_before_edge", 32'(din_rdy), 32'd0);
        tick();
        check_output("rel_rdy", 32'(din_rdy), 32'd1);
        check_output("rel_vld", 32'(dout_vld), 32'd0);
        check_output("rel_fill", 32'(fill), 32'd0);

        for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

        // Backpressure until full, then drain
        do_reset();
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            din = bp_words[(acc < 6) ? acc : 5];
            din_vld = (acc < 6);
            hs = din_rdy && din_vld;
            tick();
            if (hs) acc++;
        end
        din_vld = 1'b0;
        check_output("bp_accepted", 32'(acc), 32'd5);
        check_output("bp_fill", 32'(fill), 32'd4);
        check_output("bp_rdy", 32'(din_rdy), 32'd0);
        check_output("bp_vld", 32'(dout_vld), 32'd1);
        dout_rdy = 1'b1;
        for (int j = 0; j < 20; j++) begin
            check_output("drain_vld", 32'(dout_vld), 32'd1);
            check_output("drain_dat", 32'(dout_dat), 32'(bp_words[j/4][8*(j%4) +: 8]));
            check_output("drain_msb_dat", 32'(m_dout_dat), 32'(bp_words[j/4][8*(3-j%4) +: 8]));
            tick();
        end
        check_output("drain_idle", 32'(dout_vld), 32'd0);
        check_output("drain_fill", 32'(fill), 32'd0);
        check_output("drain_rdy", 32'(din_rdy), 32'd1);

        // Back-to-back words, no bubbles at word boundaries
        do_reset();
        dout_rdy = 1'b1;
        fork
            feed(1'b0);
            watch_lanes();
        join
        check_output("b2b_idle", 32'(dout_vld), 32'd0);

        do_reset();
        r1_dout_rdy = 1'b1;
        fork
            feed(1'b1);
            watch_words();
        join
        check_output("r1_idle", 32'(r1_dout_vld), 32'd0);

        // Flush while lane 1 is presented, with competing handshakes
        do_reset();
        for (int i = 0; i < 3; i++) begin
            din = fw[i]; din_vld = 1'b1;
            tick();
        end
        din_vld = 1'b0;
        dout_rdy = 1'b1;
        tick();
        dout_rdy = 1'b0;
        check_output("fl_lane1", 32'(dout_dat), 32'hA1);
        check_output("fl_fill_pre", 32'(fill), 32'd2);
        flush = 1'b1; din = 32'hBADBAD00; din_vld = 1'b1; dout_rdy = 1'b1;
        tick();
        flush = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0;
        check_output("fl_vld", 32'(dout_vld), 32'd0);
        check_output("fl_fill", 32'(fill), 32'd0);
        check_output("fl_rdy_low", 32'(din_rdy), 32'd0);
        tick();
        check_output("fl_rdy_back", 32'(din_rdy), 32'd1);
        check_output("fl_still_idle", 32'(dout_vld), 32'd0);
        apply_stimulus(vecs[1]);

        // Asynchronous reset between edges
        do_reset();
        din = 32'hCAFEF00D; din_vld = 1'b1;
        tick();
        din = 32'h12345678;
        tick();
        din_vld = 1'b0;
        tick();
        check_output("ar_pre_vld", 32'(dout_vld), 32'd1);
        check_output("ar_pre_fill", 32'(fill), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_output("ar_vld", 32'(dout_vld), 32'd0);
        check_output("ar_fill", 32'(fill), 32'd0);
        check_output("ar_rdy", 32'(din_rdy), 32'd0);
        check_output("ar_dat", 32'(dout_dat), 32'd0);
        tick();
        rst = 1'b0;
        dout_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_output("ar_no_stale", 32'(dout_vld), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hls_stream_width_fifo.md
Name: hls_stream_width_fifo

Overview:
- Parametrised stream buffer and width downsizer placed between HLS layer instances inside a branch top module.
- Accepts wide words on a vld/rdy input stream and buffers them in a DEPTH-entry FIFO.
- Emits each word as RATIO = IN0_DATA_WIDTH/OUT0_DATA_WIDTH narrow lanes on a vld/rdy output stream.
- Adds synchronous flush, occupancy reporting and selectable lane order. None of these exist in the plain single-layer pass-through wrapper.

Parameters:
- IN0_DATA_WIDTH, 32, input word width; must be an integer multiple of OUT0_DATA_WIDTH.
- OUT0_DATA_WIDTH, 8, output lane width; RATIO = IN0_DATA_WIDTH/OUT0_DATA_WIDTH, and RATIO >= 1.
- DEPTH, 4, FIFO entries; power of two, DEPTH >= 2.
- LSB_FIRST, 1, 1: emit lane 0 (bits OUT0_DATA_WIDTH-1:0) first; 0: emit the most significant lane first.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din_rsc_dat  input  IN0_DATA_WIDTH  input word.
- din_rsc_vld  input  1  input word valid.
- din_rsc_rdy  output  1  block can accept a word; registered.
- dout_rsc_dat  output  OUT0_DATA_WIDTH  current output lane.
- dout_rsc_vld  output  1  output lane valid.
- dout_rsc_rdy  input  1  downstream accepts lane.
- flush  input  1  synchronous drop of all buffered data.
- fill_level  output  $clog2(DEPTH+1)  FIFO entry count, 0..DEPTH; excludes the word held in the serialiser.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is asynchronous and active-high.
  - While rst is high: din_rsc_rdy=0, dout_rsc_vld=0, dout_rsc_dat=0, fill_level=0, FIFO pointers=0, serialiser in EMPTY with lane_cnt=0.
  - din_rsc_rdy goes to 1 on the first rising edge after rst deasserts.
- Handshake:
  - A transfer occurs when vld&&rdy are high at the rising edge.
  - dout_rsc_vld, once high, stays high and dout_rsc_dat stays stable until the lane is accepted or flush occurs.
- FIFO:
  - Push = din handshake. Pop = serialiser load.
  - Push and pop in the same cycle leave fill_level unchanged.
  - Pointers wrap modulo DEPTH.
  - din_rsc_rdy is registered as (next_fill_level < DEPTH).
  - No input is accepted when full. There is no overflow or underflow path.
- Serialiser FSM:
  - EMPTY: dout_rsc_vld=0. If the FIFO is non-empty, pop the head into word_q, set lane_cnt=0 and go to SHIFT.
  - SHIFT: dout_rsc_vld=1; dout_rsc_dat is lane (LSB_FIRST ? lane_cnt : RATIO-1-lane_cnt) of word_q.
    - On an output handshake with lane_cnt<RATIO-1: lane_cnt++.
    - On an output handshake with lane_cnt==RATIO-1 and the FIFO non-empty: pop the next word in the same edge, set lane_cnt=0 and stay in SHIFT (no bubble).
    - On an output handshake with lane_cnt==RATIO-1 and the FIFO empty: go to EMPTY.
- Latency and throughput:
  - A word accepted at edge N into an idle block gives dout_rsc_vld=1 after edge N+1.
  - Its first lane is therefore visible 2 cycles after the input handshake.
  - With dout_rsc_rdy held at 1, sustained output is one lane per cycle.
  - With RATIO=1, sustained throughput is one word per cycle.
- Total capacity is DEPTH+1 words: DEPTH in the FIFO plus one in the serialiser.
- flush:
  - At the edge where flush=1: fill_level becomes 0, FIFO pointers 0, serialiser EMPTY, lane_cnt 0.
  - Any din or dout handshake in the same cycle is discarded.
  - din_rsc_rdy=0 for the cycle after flush, then 1.
  - Flush takes priority over all other events.
- Reset mid-operation: all buffered data is lost, outputs go immediately to their reset values, and no partial word is emitted afterwards.
- dout_rsc_dat holds its last value in EMPTY; its value there is don't-care for the bench.

Test Plan:
- Reset/idle: hold rst high for 3 cycles, then release -> dout_rsc_vld=0, fill_level=0, din_rsc_rdy=0 during reset and 1 one edge after release.
- Single word, default parameters: push 0xDDCCBBAA with dout_rsc_rdy=1 -> lanes 0xAA, 0xBB, 0xCC, 0xDD on 4 consecutive cycles, first lane 2 cycles after input; with LSB_FIRST=0 -> 0xDD, 0xCC, 0xBB, 0xAA.
- Backpressure/full: dout_rsc_rdy=0, offer 6 words continuously -> 5 words accepted, fill_level=4, din_rsc_rdy=0. Release dout_rsc_rdy -> 20 lanes in order with no gaps, fill_level returns to 0.
- Back-to-back: stream 8 words with dout_rsc_rdy=1 -> 32 consecutive valid lanes with no bubble at word boundaries. With RATIO=1 (both widths 32) -> 8 words out on 8 consecutive cycles.
- Flush mid-word: 3 words buffered, lane 1 being presented, pulse flush -> dout_rsc_vld=0 next cycle, fill_level=0. A new word 0x11223344 is then emitted as 0x44, 0x33, 0x22, 0x11 only.
- Async reset mid-stream: assert rst between edges while in SHIFT -> dout_rsc_vld drops without waiting for a clock edge, and no stale lanes appear after release.
